weight_mem_loader: RTL and testbench

Initiator that drives a single-port weight memory (synchronous write, registered read with one-cycle latency, read data forced to zero when read is low). Loads a full weight set from an upstream valid/ready stream, then on command streams the set back out with valid/ready. Sits between the weight source (host/DMA) and the stacking datapath, as the sole master of the memory port.

---
 rtl/weight_mem_loader_pkg.sv | 18 +
 rtl/weight_mem_loader.sv | 155 +++++++++++++++
 tb/tb_weight_mem_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_mem_loader_pkg.sv
// Shared types and default sizing for the weight memory loader.
// Holds the controller state encoding and the default parameter values.
package weight_mem_pkg;

    localparam int DEPTH_DEFAULT  = 30;
    localparam int DATA_W_DEFAULT = 9;
    localparam int ADDR_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_CAP   = 3'd4,
        ST_RD_OUT   = 3'd5
    } state_e;

endpackage

// File: rtl/weight_mem_loader.sv
// Sole master of a single-port weight memory: loads a full weight set from an
// upstream stream, then streams it back out one outstanding read at a time.
module weight_mem_loader
    import weight_mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     read_start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic        [ADDR_W-1:0] mem_addr,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic signed [DATA_W-1:0] mem_wdata,
    input  logic signed [DATA_W-1:0] mem_rdata,
    output logic                     load_done,
    output logic                     read_done,
    output logic                     busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e                    state_q, state_d;
    logic        [ADDR_W-1:0]  cnt_q, cnt_d;
    logic        [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic                      mem_write_q, mem_write_d;
    logic                      mem_read_q, mem_read_d;
    logic signed [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      load_done_q, load_done_d;
    logic                      read_done_q, read_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_wdata_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            load_done_q <= 1'b0;
            read_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_wdata_q <= mem_wdata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            load_done_q <= load_done_d;
            read_done_q <= read_done_d;
        end
    end

    // Strobes and done pulses default low each cycle; address and data hold.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_wdata_d = mem_wdata_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load_done_d = 1'b0;
        read_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (read_start) begin
                    state_d = ST_RD_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = in_data;
                    if (cnt_q == LAST_ADDR) begin
                        state_d     = ST_IDLE;
                        load_done_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_RD_ISSUE: begin
                mem_read_d = 1'b1;
                mem_addr_d = cnt_q;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                out_data_d  = mem_rdata;
                out_valid_d = 1'b1;
                out_last_d  = (cnt_q == LAST_ADDR);
                state_d     = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        read_done_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign mem_wdata = mem_wdata_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign load_done = load_done_q;
    assign read_done = read_done_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Bench for weight_mem_loader: a behavioural single-port memory on the mem_*
// port, a shadow copy of the loaded set as reference, and one task per scenario.
module tb_weight_mem_loader;

    localparam int DEPTH  = 30;
    localparam int DATA_W = 9;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              load_start = 1'b0;
    logic              read_start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              load_done;
    logic              read_done;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DATA_W-1:0] load_w    [DEPTH];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mem_arr   [0:(1<<ADDR_W)-1];

    int                mon_cyc = 0;
    int                acc_cyc_q[$];
    int                wr_cyc_q[$];
    logic [ADDR_W-1:0] wr_a_q[$];
    logic [DATA_W-1:0] wr_d_q[$];
    logic [ADDR_W-1:0] rd_a_q[$];
    int                ld_done_n = 0;
    int                ld_done_cyc = 0;
    int                rd_done_n = 0;

    always #5 clk = ~clk;

    weight_mem_loader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .read_start(read_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .load_done(load_done), .read_done(read_done), .busy(busy)
    );

    // Synchronous write, registered read, read data zero when not reading.
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr] <= mem_wdata;
        mem_rdata <= mem_read ? mem_arr[mem_addr] : '0;
    end

    always @(negedge clk) begin
        mon_cyc++;
        if (in_valid && in_ready) acc_cyc_q.push_back(mon_cyc);
        if (mem_write) begin
            wr_cyc_q.push_back(mon_cyc);
            wr_a_q.push_back(mem_addr);
            wr_d_q.push_back(mem_wdata);
        end
        if (mem_read) rd_a_q.push_back(mem_addr);
        if (load_done) begin
            ld_done_n++;
            ld_done_cyc = mon_cyc;
        end
        if (read_done) rd_done_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d passed=%0d", total_cnt, pass_cnt);
        $fatal(1);
    end

    task automatic clear_mon();
        acc_cyc_q.delete();
        wr_cyc_q.delete();
        wr_a_q.delete();
        wr_d_q.delete();
        rd_a_q.delete();
        ld_done_n = 0;
        rd_done_n = 0;
    endtask

    task automatic test_reset();
        logic [30:0] outs;
        #2 rst_n = 1'b0;
        #1;
        outs = {in_ready, out_valid, out_data, out_last, mem_addr, mem_write,
                mem_read, mem_wdata, load_done, read_done, busy};
        total_cnt++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL reset_idle: busy=%b in_ready=%b expected 0 0", busy, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_load(input string name, input bit toggle, input bit both, input bit poke);
        logic acc_now;
        int   guard;
        clear_mon();
        @(posedge clk); #1;
        load_start = 1'b1;
        read_start = both;
        @(posedge clk); #1;
        load_start = 1'b0;
        read_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = load_w[i];
            if (poke && i == 11) begin
                load_start = 1'b1;
                read_start = 1'b1;
            end
            guard = 0;
            do begin
                acc_now = in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc_now && guard < 50);
            load_start = 1'b0;
            read_start = 1'b0;
            if (guard >= 50) begin
                total_cnt++;
                $display("FAIL %s_accept_timeout: word %0d not accepted in 50 cycles", name, i);
            end
            in_valid = 1'b0;
            if (toggle) begin
                @(posedge clk); #1;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = load_w[i];

        total_cnt++;
        if (wr_a_q.size() !== DEPTH || acc_cyc_q.size() !== DEPTH)
            $display("FAIL %s_write_count: writes=%0d accepts=%0d expected %0d", name, wr_a_q.size(), acc_cyc_q.size(), DEPTH);
        else pass_cnt++;
        for (int i = 0; i < DEPTH && i < wr_a_q.size() && i < acc_cyc_q.size(); i++) begin
            total_cnt++;
            if (wr_a_q[i] !== ADDR_W'(i) || wr_d_q[i] !== load_w[i] || wr_cyc_q[i] !== acc_cyc_q[i] + 1)
                $display("FAIL %s_write_%0d: addr=%0d data=%0d cyc=%0d expected addr=%0d data=%0d cyc=%0d",
                         name, i, wr_a_q[i], $signed(wr_d_q[i]), wr_cyc_q[i], i, $signed(load_w[i]), acc_cyc_q[i] + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if (ld_done_n !== 1 || acc_cyc_q.size() == 0 || ld_done_cyc !== acc_cyc_q[acc_cyc_q.size()-1] + 1)
            $display("FAIL %s_load_done: pulses=%0d cyc=%0d expected 1 pulse one cycle after last accept", name, ld_done_n, ld_done_cyc);
        else pass_cnt++;
        total_cnt++;
        if (rd_a_q.size() !== 0 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL %s_after_load: mem_reads=%0d busy=%b in_ready=%b expected 0 0 0", name, rd_a_q.size(), busy, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_read(input string name, input int stall_word, input bit poke);
        int n, guard, lc, seen_cyc, prev_cyc, stall_left, rd_mark;
        bit seen, poked;
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(model_mem[i]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        read_start = 1'b1;
        @(posedge clk); #1;
        read_start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (mem_read !== 1'b0 || busy !== 1'b1) $display("FAIL %s_s0: mem_read=%b busy=%b expected 0 1", name, mem_read, busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (mem_read !== 1'b1 || mem_addr !== '0) $display("FAIL %s_s1_read: mem_read=%b addr=%0d expected 1 0", name, mem_read, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (mem_read !== 1'b0 || out_valid !== 1'b0) $display("FAIL %s_s2: mem_read=%b out_valid=%b expected 0 0", name, mem_read, out_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL %s_s3_valid: out_valid=%b expected 1", name, out_valid);
        else pass_cnt++;

        n = 0; guard = 0; lc = 0; prev_cyc = 0; seen_cyc = 0; rd_mark = 0;
        stall_left = 5; seen = 1'b0; poked = 1'b0;
        while (n < DEPTH && guard < 1000) begin
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    seen_cyc = lc;
                    if (n > 0 && n - 1 != stall_word) begin
                        total_cnt++;
                        if (seen_cyc - prev_cyc !== 4) $display("FAIL %s_gap_%0d: got %0d cycles expected 4", name, n, seen_cyc - prev_cyc);
                        else pass_cnt++;
                    end
                end
                if (n == stall_word && stall_left > 0) begin
                    out_ready = 1'b0;
                    if (stall_left == 5) rd_mark = rd_a_q.size();
                    total_cnt++;
                    if (out_data !== exp_q[n]) $display("FAIL %s_stall_hold: got %0d expected %0d", name, $signed(out_data), $signed(exp_q[n]));
                    else pass_cnt++;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    total_cnt++;
                    if (out_data !== exp_q[n] || out_last !== (n == DEPTH - 1))
                        $display("FAIL %s_word_%0d: data=%0d last=%b expected data=%0d last=%b",
                                 name, n, $signed(out_data), out_last, $signed(exp_q[n]), (n == DEPTH - 1));
                    else pass_cnt++;
                    if (n == stall_word) begin
                        total_cnt++;
                        if (rd_a_q.size() !== rd_mark) $display("FAIL %s_stall_no_read: reads=%0d expected %0d", name, rd_a_q.size(), rd_mark);
                        else pass_cnt++;
                    end
                    prev_cyc = seen_cyc;
                    seen = 1'b0;
                    n++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (poke && n == 7 && !poked) begin
                load_start = 1'b1;
                read_start = 1'b1;
                poked = 1'b1;
            end else begin
                load_start = 1'b0;
                read_start = 1'b0;
            end
            if (n < DEPTH) begin
                @(negedge clk);
                lc++;
                guard++;
            end
        end
        load_start = 1'b0;
        read_start = 1'b0;
        total_cnt++;
        if (guard >= 1000) $display("FAIL %s_timeout: got %0d words expected %0d", name, n, DEPTH);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (read_done !== 1'b1 || busy !== 1'b0) $display("FAIL %s_read_done: read_done=%b busy=%b expected 1 0", name, read_done, busy);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if (rd_done_n !== 1 || rd_a_q.size() !== DEPTH || wr_a_q.size() !== 0 || in_ready !== 1'b0)
            $display("FAIL %s_summary: done=%0d reads=%0d writes=%0d in_ready=%b expected 1 %0d 0 0",
                     name, rd_done_n, rd_a_q.size(), wr_a_q.size(), in_ready, DEPTH);
        else pass_cnt++;
        for (int i = 0; i < DEPTH && i < rd_a_q.size(); i++) begin
            total_cnt++;
            if (rd_a_q[i] !== ADDR_W'(i)) $display("FAIL %s_read_addr_%0d: got %0d expected %0d", name, i, rd_a_q[i], i);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_read();
        int n, guard;
        logic [30:0] outs;
        n = 0; guard = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        read_start = 1'b1;
        @(posedge clk); #1;
        read_start = 1'b0;
        @(negedge clk);
        while (!(n == 12 && out_valid) && guard < 500) begin
            if (out_valid) n++;
            @(negedge clk);
            guard++;
        end
        total_cnt++;
        if (guard >= 500) $display("FAIL mid_reset_reach: got %0d words expected 12", n);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        outs = {in_ready, out_valid, out_data, out_last, mem_addr, mem_write,
                mem_read, mem_wdata, load_done, read_done, busy};
        total_cnt++;
        if (outs !== '0) $display("FAIL mid_reset_async: got %h expected 0", outs);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || rd_a_q.size() !== 0)
            $display("FAIL mid_reset_idle: busy=%b in_ready=%b out_valid=%b reads=%0d expected 0 0 0 0",
                     busy, in_ready, out_valid, rd_a_q.size());
        else pass_cnt++;
    endtask

    initial begin
        int base [5];
        base = '{0, 1, -1, 255, -256};
        test_reset();

        for (int i = 0; i < DEPTH; i++) load_w[i] = (i < 5) ? DATA_W'(base[i]) : DATA_W'(i);
        test_load("load_held", 1'b0, 1'b0, 1'b0);
        test_read("read_fast", -1, 1'b0);
        test_read("read_stall", 3, 1'b0);

        for (int i = 0; i < DEPTH; i++) load_w[i] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        test_load("load_toggle", 1'b1, 1'b0, 1'b0);
        test_read("read_poked", -1, 1'b1);

        for (int i = 0; i < DEPTH; i++) load_w[i] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        test_load("load_both", 1'b0, 1'b1, 1'b1);
        test_read("read_after_both", $urandom_range(0, DEPTH - 1), 1'b0);

        test_reset_mid_read();
        test_read("read_after_reset", -1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
